// File: rtl/regfile_pkg.sv
// Shared regfile definitions: register geometry and the writeback request record.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    // True when a destination register is the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [REG_AW-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wport_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module rr_pick #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic          found_s;
    logic [PW:0]   idx_s;

    // Scan ptr, ptr+1, ... (mod N) and grant the first active request.
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_idx = {PW{1'b0}};
        found_s = 1'b0;
        idx_s   = {(PW+1){1'b0}};
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr} + (PW+1)'(k);
            if (idx_s >= (PW+1)'(N)) begin
                idx_s = idx_s - (PW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s[PW-1:0]]) begin
                found_s                 = 1'b1;
                gnt[idx_s[PW-1:0]]      = 1'b1;
                gnt_idx                 = idx_s[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arb.sv
// Round-robin arbiter for the single regfile write port. The winning request is
// captured into an output register and reaches the regfile one cycle later.
module regfile_wport_arb
    import regfile_pkg::*;
#(
    parameter  int NREQ = 3,
    parameter  int AW   = REG_AW,
    parameter  int DW   = REG_DW,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic             wp_hold,
    output logic             we,
    output logic [AW-1:0]    waddr,
    output logic [DW-1:0]    wdata,
    output logic             busy
);

    logic [NREQ-1:0] pick_req_s;
    logic [NREQ-1:0] gnt_s;
    logic [PW-1:0]   gnt_idx_s;
    logic            xfer_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;

    logic [PW-1:0]   ptr_d,   ptr_q;
    logic            we_d,    we_q;
    logic [AW-1:0]   waddr_d, waddr_q;
    logic [DW-1:0]   wdata_d, wdata_q;

    // Hold masks every request so no grant (and hence no transfer) can occur.
    assign pick_req_s = req_valid & {NREQ{~wp_hold}};

    rr_pick #(.N(NREQ)) u_pick (
        .req     (pick_req_s),
        .ptr     (ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // The picker only grants valid requesters, so any grant is a transfer.
    assign req_ready = gnt_s & {NREQ{rst_n}};
    assign xfer_s    = |gnt_s;

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel_addr_s = {AW{1'b0}};
        sel_data_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                sel_addr_s = req_addr[i*AW +: AW];
                sel_data_s = req_data[i*DW +: DW];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Next-state: capture the winner, suppress enable for r0, advance pointer past the winner.
    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (xfer_s) begin
            we_d    = (sel_addr_s != {AW{1'b0}});
            waddr_d = sel_addr_s;
            wdata_d = sel_data_s;
            if (gnt_idx_s == PW'(NREQ - 1)) begin
                ptr_d = {PW{1'b0}};
            end else begin
                ptr_d = gnt_idx_s + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer and write-port output register; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= {PW{1'b0}};
            we_q    <= 1'b0;
            waddr_q <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = (|req_valid) | we_q;

endmodule
